// File: rtl/inv_stim_checker_if.sv
// Stimulus/response bundle between the inverter checker and its harness.
// The checker uses the slave side: it drives stim and the result signals, and samples start and resp.
interface inv_stim_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stim;
  logic             resp;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             error;
  logic [CNT_W-1:0] first_fail_idx;

  modport master (
    output start, resp,
    input  stim, busy, done, pass_cnt, fail_cnt, error, first_fail_idx
  );

  modport slave (
    input  start, resp,
    output stim, busy, done, pass_cnt, fail_cnt, error, first_fail_idx
  );
endinterface

// File: rtl/inv_stim_checker.sv
// Square-wave inverter checker: stim toggles every HALF_PERIOD cycles, and resp is sampled at phase cycle SETTLE.
// Each sample's result is visible one cycle later; there is no backpressure. INV_CHK_STOP_ON_FAIL_EN ends a run on its first mismatch.
module inv_stim_checker #(
  parameter int HALF_PERIOD = 20,
  parameter int SETTLE      = 2,
  parameter int NUM_TOGGLES = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  inv_stim_checker_if.slave bus
);

  localparam int               CYC_W      = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CYC_W-1:0] CYC_SAMPLE = CYC_W'(SETTLE);
  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] PH_LAST    = CNT_W'(NUM_TOGGLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             stim_q, stim_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cyc_d   = cyc_q;
    stim_d  = stim_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    error_d = error_q;
    ffi_d   = ffi_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          ph_d    = '0;
          cyc_d   = '0;
          stim_d  = 1'b0;
          pass_d  = '0;
          fail_d  = '0;
          error_d = 1'b0;
          ffi_d   = '0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CYC_LAST) begin
          if (ph_q == PH_LAST) begin
            state_d = S_DONE;
            stim_d  = 1'b0;
          end else begin
            stim_d = ~stim_q;
            ph_d   = ph_q + 1'b1;
            cyc_d  = '0;
          end
        end
        // Case equality so an X/Z resp from a floating switch network counts as a mismatch.
        if (cyc_q == CYC_SAMPLE) begin
          if (bus.resp === ~stim_q) begin
            if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
          end else begin
            if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
            if (!error_q) begin
              error_d = 1'b1;
              ffi_d   = ph_q;
            end
`ifdef INV_CHK_STOP_ON_FAIL_EN
            state_d = S_DONE;
            stim_d  = 1'b0;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      cyc_q   <= '0;
      stim_q  <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      error_q <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cyc_q   <= cyc_d;
      stim_q  <= stim_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      error_q <= error_d;
      ffi_q   <= ffi_d;
    end
  end

  assign bus.stim           = stim_q;
  assign bus.busy           = (state_q == S_RUN);
  assign bus.done           = (state_q == S_DONE);
  assign bus.pass_cnt       = pass_q;
  assign bus.fail_cnt       = fail_q;
  assign bus.error          = error_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_inv_stim_checker.sv
// Randomised scoreboard bench for inv_stim_checker: expected run results are queued at start and checked when done rises.
module tb_inv_stim_checker;
  localparam int HP = 20;
  localparam int ST = 2;
  localparam int NT = 15;
  localparam int CW = 16;

  typedef struct {
    int pass_n;
    int fail_n;
    int err;
    int ffi;
    int len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_stim_checker_if #(.CNT_W(CW)) bus ();

  inv_stim_checker #(
    .HALF_PERIOD(HP),
    .SETTLE     (ST),
    .NUM_TOGGLES(NT),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t          exp_q[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            mode = 0;
  logic [NT-1:0] mask = '0;
  int            drv_cyc = 0;
  int            mon_cyc = 0;
  bit            done_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Response seen in phase k: 0 inverter, 1 tied low, 2 buffer, 3 inverter with masked phases flipped.
  function automatic bit resp_of(input int m, input int k, input logic [NT-1:0] mk);
    bit s;
    s = k[0];
    case (m)
      0:       return !s;
      1:       return 1'b0;
      2:       return s;
      default: return (!s) ^ mk[k];
    endcase
  endfunction

  function automatic exp_t model(input int m, input logic [NT-1:0] mk);
    exp_t e;
    e.pass_n = 0;
    e.fail_n = 0;
    e.err    = 0;
    e.ffi    = 0;
    e.len    = NT * HP;
    for (int k = 0; k < NT; k++) begin
      if (resp_of(m, k, mk) == !k[0]) begin
        e.pass_n++;
      end else begin
        e.fail_n++;
        if (e.err == 0) begin
          e.err = 1;
          e.ffi = k;
        end
`ifdef INV_CHK_STOP_ON_FAIL_EN
        e.len = k * HP + ST + 1;
        break;
`endif
      end
    end
    return e;
  endfunction

  // Response driver: real inverter/buffer use the live stim, other modes use the phase number.
  initial begin
    bus.resp = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        case (mode)
          0:       bus.resp = ~bus.stim;
          2:       bus.resp = bus.stim;
          default: bus.resp = resp_of(mode, drv_cyc / HP, mask);
        endcase
        drv_cyc++;
      end else begin
        drv_cyc = 0;
      end
    end
  end

  // Monitor: checks stim parity every busy cycle and scores each completed run.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_cyc   = 0;
        done_prev = 1'b0;
      end else begin
        if (bus.busy) begin
          check("stim_phase", bus.stim, (mon_cyc / HP) % 2);
          mon_cyc++;
        end
        if (bus.done && !done_prev) begin
          if (exp_q.size() == 0) begin
            check("done_without_start", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("pass_cnt", bus.pass_cnt, e.pass_n);
            check("fail_cnt", bus.fail_cnt, e.fail_n);
            check("error", bus.error, e.err);
            check("first_fail_idx", bus.first_fail_idx, e.ffi);
            check("busy_len", mon_cyc, e.len);
          end
          mon_cyc = 0;
        end
        done_prev = bus.done;
      end
    end
  end

  task automatic start_run(input int m, input logic [NT-1:0] mk);
    mode = m;
    mask = mk;
    exp_q.push_back(model(m, mk));
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("done_clear_on_start", bus.done, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < NT * HP + 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_within_budget", bus.done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_stim"}, bus.stim, 0);
    check({tag, "_pass"}, bus.pass_cnt, 0);
    check({tag, "_fail"}, bus.fail_cnt, 0);
    check({tag, "_error"}, bus.error, 0);
    check({tag, "_ffi"}, bus.first_fail_idx, 0);
  endtask

  initial begin
    exp_t dropped;
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal inverter, then check done is held with stim low.
    start_run(0, '0);
    wait_done();
    repeat (10) @(negedge clk);
    check("done_held", bus.done, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_stim", bus.stim, 0);

    start_run(1, '0);
    wait_done();
    start_run(2, '0);
    wait_done();

    // Asynchronous reset mid-run discards the run.
    start_run(0, '0);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    dropped = exp_q.pop_back();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(0, '0);
    wait_done();

    // Extra start pulses during a run are ignored.
    start_run(0, '0);
    repeat (48) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Single mismatch in the final phase, then random corruption patterns.
    start_run(3, NT'(1) << (NT - 1));
    wait_done();
    for (int r = 0; r < 5; r++) begin
      start_run(3, NT'($urandom));
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
